// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle between pipeline control and the sequential ALU.
interface alu_seq_unit_if #(parameter int N = 32);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [3:0]   sel_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [N-1:0] result_o;
  logic         zero_o;
  logic         busy_o;

  modport master (
    output in_valid_i, sel_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, busy_o
  );

  modport slave (
    input  in_valid_i, sel_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU ops; shift codes and unknown codes produce 0 here.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   i_sel,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_result
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  // op select; anything unrecognised (including shifts) yields zero
  always_comb begin
    o_result = '0;
    case (i_sel)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLT:  o_result = {{(N-1){1'b0}}, w_lt_s};
      ALU_SLTU: o_result = {{(N-1){1'b0}}, w_lt_u};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle ops complete on accept, shifts step one bit per cycle.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | iterating a shift, one bit per cycle
// DONE  | result valid, waiting for consumer
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  alu_seq_unit_if.slave bus
);

  localparam int SHW = $clog2(N);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_opnd;
  logic [N-1:0]   r_result;
  logic [SHW-1:0] r_count;
  logic [3:0]     r_op;
  logic [N-1:0]   w_comb_res;
  logic [N-1:0]   w_shift_nxt;
  logic [SHW-1:0] w_shamt;
  logic           w_accept;
  logic           w_shift_start;
  logic           w_last_shift;

  assign w_shamt       = bus.b_i[SHW-1:0];
  assign w_accept      = (r_state == ST_IDLE) && bus.in_valid_i;
  assign w_shift_start = is_shift(bus.sel_i) && (w_shamt != '0);
  assign w_last_shift  = (r_count == SHW'(1));

  alu_comb_ops #(.N(N)) u_comb (
    .i_sel    (bus.sel_i),
    .i_a      (bus.a_i),
    .i_b      (bus.b_i),
    .o_result (w_comb_res)
  );

  // one-bit step of the latched shift operand
  always_comb begin
    w_shift_nxt = r_opnd;
    case (r_op)
      ALU_SLL: w_shift_nxt = {r_opnd[N-2:0], 1'b0};
      ALU_SRL: w_shift_nxt = {1'b0, r_opnd[N-1:1]};
      ALU_SRA: w_shift_nxt = {r_opnd[N-1], r_opnd[N-1:1]};
      default: w_shift_nxt = r_opnd;
    endcase
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_shift_start ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (w_last_shift) w_state_nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // operand capture, shift iteration and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opnd   <= '0;
      r_count  <= '0;
      r_op     <= ALU_AND;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_shift_start) begin
              r_opnd  <= bus.a_i;
              r_count <= w_shamt;
              r_op    <= bus.sel_i;
            end else begin
              // a zero-distance shift passes operand A straight through
              r_result <= is_shift(bus.sel_i) ? bus.a_i : w_comb_res;
            end
          end
        end
        ST_SHIFT: begin
          r_opnd  <= w_shift_nxt;
          r_count <= r_count - SHW'(1);
          if (w_last_shift) r_result <= w_shift_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == ST_IDLE);
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.busy_o      = (r_state == ST_SHIFT);
  assign bus.result_o    = r_result;
  assign bus.zero_o      = (r_result == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and randomized checks of alu_seq_unit against a plain-arithmetic model.
module tb_alu_seq_unit;

  localparam int N = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq_unit_if #(.N(N)) bus ();

  alu_seq_unit #(.N(N)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [3:0] sel, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    int sh;
    logic signed [N-1:0] sa;
    sh = int'(b % N);
    sa = a;
    case (sel)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: return (a < b) ? 1 : 0;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b1001: return sa >>> sh;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] sel, input logic [N-1:0] b);
    int sh;
    sh = int'(b % N);
    if ((sel == 4'b0100 || sel == 4'b0101 || sel == 4'b1001) && sh != 0) return sh + 1;
    return 1;
  endfunction

  task automatic do_op(input logic [3:0] sel, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int hold);
    logic [N-1:0] exp;
    int exp_lat, lat, busy_cnt, rdy_hi;
    bit done;
    exp     = ref_model(sel, a, b);
    exp_lat = ref_latency(sel, b);
    @(negedge clk_i);
    chk("idle_ready", N'(bus.in_ready_o), N'(1));
    bus.in_valid_i  = 1'b1;
    bus.sel_i       = sel;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.out_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    // scramble inputs after accept; the DUT must have sampled them already
    bus.in_valid_i = 1'b0;
    bus.sel_i      = 4'($urandom);
    bus.a_i        = $urandom;
    bus.b_i        = $urandom;
    lat = 0; busy_cnt = 0; rdy_hi = 0; done = 0;
    while (!done && lat < 100) begin
      @(negedge clk_i);
      lat++;
      if (bus.busy_o) busy_cnt++;
      if (bus.in_ready_o) rdy_hi++;
      if (bus.out_valid_o) done = 1;
    end
    chk("latency", N'(lat), N'(exp_lat));
    chk("busy_cycles", N'(busy_cnt), N'(exp_lat - 1));
    chk("ready_low_while_busy", N'(rdy_hi), N'(0));
    chk("result", bus.result_o, exp);
    chk("zero", N'(bus.zero_o), N'(exp == 0));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid_i = 1'b1;
      bus.sel_i      = 4'b0010;
      bus.a_i        = $urandom;
      bus.b_i        = $urandom;
      @(negedge clk_i);
      chk("hold_valid", N'(bus.out_valid_o), N'(1));
      chk("hold_result", bus.result_o, exp);
      chk("hold_not_ready", N'(bus.in_ready_o), N'(0));
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("release_valid", N'(bus.out_valid_o), N'(0));
    chk("release_ready", N'(bus.in_ready_o), N'(1));
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [12];
    logic [3:0] s;
    logic [N-1:0] ra, rb;
    codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0111,
              4'b1000, 4'b0100, 4'b0101, 4'b1001, 4'b1111, 4'b1010};
    rst_ni          = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.sel_i       = '0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    #1;
    chk("rst_valid", N'(bus.out_valid_o), N'(0));
    chk("rst_busy", N'(bus.busy_o), N'(0));
    chk("rst_result", bus.result_o, '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", N'(bus.in_ready_o), N'(1));

    do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op(4'b0110, 32'd5, 32'd7, 0);
    do_op(4'b0110, 32'h1234, 32'h1234, 0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1001, 32'h8000_0000, 32'h0000_0024, 0);
    do_op(4'b0100, 32'd1, 32'd31, 0);
    do_op(4'b0101, 32'h8000_0000, 32'h0000_0020, 0);
    do_op(4'b1111, $urandom, $urandom, 0);
    do_op(4'b0001, 32'hF0, 32'h0F, 3);

    // async reset during the third SHIFT cycle of SLL by 10
    @(negedge clk_i);
    bus.in_valid_i = 1'b1;
    bus.sel_i      = 4'b0100;
    bus.a_i        = 32'd3;
    bus.b_i        = 32'd10;
    @(posedge clk_i);
    #1 bus.in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("pre_rst_busy", N'(bus.busy_o), N'(1));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", N'(bus.busy_o), N'(0));
    chk("mid_rst_valid", N'(bus.out_valid_o), N'(0));
    chk("mid_rst_result", bus.result_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", N'(bus.out_valid_o), N'(0));
    do_op(4'b0010, 32'd100, 32'd23, 0);

    for (int k = 0; k < 40; k++) begin
      s  = codes[$urandom_range(0, 11)];
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 40)) : N'($urandom);
      do_op(s, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
